program_loader: RTL and testbench
=================================

# program_loader

Host-side writer for the microprocessor's program memory. It accepts a stream of 16-bit words over a valid/ready handshake and assembles each pair into one 32-bit instruction. It writes each instruction to program memory at consecutive addresses starting at 0, and holds the CPU in reset until a complete program has been loaded. It sits between the external host link and the program memory write port, and drives the CPU core's reset.

## Interface
Parameters:
- PM_DEPTH, 256, number of 32-bit instruction slots in program memory (max program length)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  request a new load session; sampled in IDLE only
- load_len  in  16  number of 32-bit instructions to load; sampled with start
- in_valid  in  1  host word valid
- in_data  in  16  host word
- in_ready  out  1  loader accepts in_data this cycle
- pm_we  out  1  program memory write strobe, one cycle per instruction
- pm_addr  out  16  program memory write address
- pm_wdata  out  32  instruction to write
- cpu_reset  out  1  hold CPU core (PC, registers) in reset
- busy  out  1  load session in progress
- done  out  1  one-cycle pulse on successful completion
- err  out  1  one-cycle pulse when start is rejected

## Operation
- FSM states: IDLE, HI, LO, WRITE, DONE. All outputs are Moore, decoded from registered state. There is no combinational input-to-output path.
- IDLE: in_ready=0, busy=0, pm_we=0.
  - start=1 with 1 ≤ load_len ≤ PM_DEPTH: latch load_len, clear addr to 0, set cpu_reset=1, go to HI.
  - start=1 with load_len=0 or load_len>PM_DEPTH: err=1 for the next cycle, stay in IDLE, cpu_reset unchanged.
- HI: in_ready=1, busy=1. On in_valid&in_ready, capture in_data into instruction[31:16] and go to LO. Otherwise hold.
- LO: in_ready=1. On handshake, capture in_data into instruction[15:0] and go to WRITE.
- WRITE: in_ready=0, pm_we=1, pm_addr=addr, pm_wdata=assembled word. At the edge, addr increments.
  - If the written addr == load_len−1, go to DONE.
  - Otherwise go to HI.
- DONE: done=1, busy=1, in_ready=0. Next state is IDLE. cpu_reset is cleared to 0 at the DONE→IDLE edge.
- start is ignored in every state except IDLE. There is no abort input.
- Word order is fixed: the first word of each pair is the upper half.
- addr is 16 bits and upper bits are zero-extended. Because load_len ≤ PM_DEPTH, addr never wraps.
- pm_addr and pm_wdata hold their last values outside WRITE. They are only meaningful while pm_we=1.

## Timing
- Reset values: state=IDLE, in_ready=0, pm_we=0, pm_addr=0, pm_wdata=0, busy=0, done=0, err=0, cpu_reset=1.
- cpu_reset stays 1 from reset until the first successful load completes.
- Start accepted at edge T: busy=1 and in_ready=1 from cycle T+1.
- Each instruction takes at least 3 cycles (HI, LO, WRITE) with in_valid held high. An N-instruction load with no stalls finishes with done=1 in cycle T+1+3N, and cpu_reset=0 from cycle T+2+3N.
- Stalls: with in_valid=0 the FSM holds in HI/LO indefinitely with no timeout. Data is taken only on an edge where in_valid&in_ready=1.
- err asserts in cycle T+1 for a start rejected at edge T.
- Reset mid-session: asynchronous return to all reset values. Writes already made to memory remain, but cpu_reset=1 prevents execution. A new start always reloads from address 0.

## Test plan
- Reset: assert reset mid-clock -> immediately in_ready=0, pm_we=0, busy=0, cpu_reset=1, done=0, err=0.
- Basic load: load_len=2, in_valid=1 streaming 0x1234, 0x5678, 0x9ABC, 0xDEF0 -> pm_we pulses at addr 0 with 0x12345678, then at addr 1 with 0x9ABCDEF0; done pulses at T+7; cpu_reset=0 from T+8.
- Backpressure: load_len=1, in_valid toggles 1,0,0,1 -> pm_we fires exactly once with the two valid words, never during gaps; words presented while in_ready=0 (WRITE/DONE) are not consumed.
- Rejection: start with load_len=0, then with load_len=257 (PM_DEPTH=256) -> err pulses one cycle each, busy stays 0, no pm_we, cpu_reset unchanged.
- Reset mid-load: load_len=4, assert reset after the 2nd pm_we -> outputs return to reset values; a following start with load_len=1 writes addr 0.
- Full depth and busy start: load_len=256 -> 256 writes, last at pm_addr=0x00FF, done once; start pulses during the session are ignored (no restart, no err).

Source files
------------

// File: rtl/program_loader.sv
// Assembles 16-bit host words (upper half first) into 32-bit instructions,
// writes them to program memory from address 0 and holds the CPU in reset until done.
module program_loader #(
  parameter int PM_DEPTH = 256
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [15:0] load_len_i,
  input  logic        in_valid_i,
  input  logic [15:0] in_data_i,
  output logic        in_ready_o,
  output logic        pm_we_o,
  output logic [15:0] pm_addr_o,
  output logic [31:0] pm_wdata_o,
  output logic        cpu_reset_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_WRITE, S_DONE} state_t;

  localparam logic [16:0] DEPTH_W = 17'(PM_DEPTH);

  state_t      state_q;
  logic [15:0] addr_q;
  logic [15:0] len_q;
  logic [15:0] hi_q;
  logic        in_ready_q;
  logic        pm_we_q;
  logic [15:0] pm_addr_q;
  logic [31:0] pm_wdata_q;
  logic        cpu_reset_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;

  logic len_ok;
  logic hs;

  assign len_ok = (load_len_i != 16'd0) && ({1'b0, load_len_i} <= DEPTH_W);
  // Handshake uses the registered ready, so no input reaches an output combinationally.
  assign hs     = in_valid_i & in_ready_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      hi_q        <= '0;
      in_ready_q  <= 1'b0;
      pm_we_q     <= 1'b0;
      pm_addr_q   <= '0;
      pm_wdata_q  <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      pm_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (len_ok) begin
              len_q       <= load_len_i;
              addr_q      <= '0;
              cpu_reset_q <= 1'b1;
              busy_q      <= 1'b1;
              in_ready_q  <= 1'b1;
              state_q     <= S_HI;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_HI: begin
          if (hs) begin
            hi_q    <= in_data_i;
            state_q <= S_LO;
          end
        end
        S_LO: begin
          if (hs) begin
            pm_wdata_q <= {hi_q, in_data_i};
            pm_addr_q  <= addr_q;
            pm_we_q    <= 1'b1;
            in_ready_q <= 1'b0;
            state_q    <= S_WRITE;
          end
        end
        S_WRITE: begin
          addr_q <= addr_q + 16'd1;
          if (addr_q == len_q - 16'd1) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= S_HI;
          end
        end
        S_DONE: begin
          busy_q      <= 1'b0;
          cpu_reset_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign pm_we_o     = pm_we_q;
  assign pm_addr_o   = pm_addr_q;
  assign pm_wdata_o  = pm_wdata_q;
  assign cpu_reset_o = cpu_reset_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: cycle-exact checks plus a write monitor
// that compares every program memory write against the word stream fed in.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [15:0] load_len_i;
  logic        in_valid_i;
  logic [15:0] in_data_i;
  logic        in_ready_o;
  logic        pm_we_o;
  logic [15:0] pm_addr_o;
  logic [31:0] pm_wdata_o;
  logic        cpu_reset_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  program_loader #(.PM_DEPTH(256)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .load_len_i  (load_len_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .pm_we_o     (pm_we_o),
    .pm_addr_o   (pm_addr_o),
    .pm_wdata_o  (pm_wdata_o),
    .cpu_reset_o (cpu_reset_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  logic [15:0] words[$];
  int          widx;
  int          we_count;
  int          done_count;
  int          err_count;
  logic [15:0] last_addr;

  function automatic logic [15:0] wd(input int i);
    if (i < words.size()) return words[i];
    return 16'hDEAD;
  endfunction

  // Every write must land at the next address with the next pair of stream words.
  always @(negedge clk) begin
    if (pm_we_o) begin
      check("pm_addr_seq", 32'(pm_addr_o), 32'(we_count));
      check("pm_wdata_seq", pm_wdata_o, {wd(2 * we_count), wd(2 * we_count + 1)});
      $display("write addr=%04h data=%08h", pm_addr_o, pm_wdata_o);
      last_addr = pm_addr_o;
      we_count++;
    end
    if (done_o) done_count++;
    if (err_o)  err_count++;
  end

  // Advance the stream only when the word was actually taken at this edge.
  task automatic tick();
    logic hs;
    hs = in_valid_i && in_ready_o;
    @(posedge clk);
    #1;
    if (hs) begin
      widx++;
      in_data_i = wd(widx);
    end
  endtask

  task automatic do_start(input logic [15:0] len);
    start_i    = 1'b1;
    load_len_i = len;
    tick();
    start_i    = 1'b0;
  endtask

  task automatic new_session();
    widx       = 0;
    in_data_i  = wd(0);
    we_count   = 0;
    done_count = 0;
    err_count  = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    reset_i    = 1'b1;
    start_i    = 1'b0;
    load_len_i = 16'd0;
    in_valid_i = 1'b0;
    in_data_i  = 16'd0;
    widx = 0; we_count = 0; done_count = 0; err_count = 0; last_addr = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready_o), 32'd0);
    check("rst_pm_we", 32'(pm_we_o), 32'd0);
    check("rst_pm_addr", 32'(pm_addr_o), 32'd0);
    check("rst_pm_wdata", pm_wdata_o, 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset_o), 32'd1);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    reset_i = 1'b0;
    tick();

    // Basic two-instruction load, start accepted at edge T.
    words = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    new_session();
    in_valid_i = 1'b1;
    do_start(16'd2);
    check("basic_busy_t1", 32'(busy_o), 32'd1);
    check("basic_ready_t1", 32'(in_ready_o), 32'd1);
    tick(); tick();
    check("basic_we_t3", 32'(pm_we_o), 32'd1);
    check("basic_addr_t3", 32'(pm_addr_o), 32'h0000);
    check("basic_data_t3", pm_wdata_o, 32'h12345678);
    check("basic_ready_t3", 32'(in_ready_o), 32'd0);
    tick(); tick(); tick();
    check("basic_we_t6", 32'(pm_we_o), 32'd1);
    check("basic_addr_t6", 32'(pm_addr_o), 32'h0001);
    check("basic_data_t6", pm_wdata_o, 32'h9ABCDEF0);
    tick();
    check("basic_done_t7", 32'(done_o), 32'd1);
    check("basic_cpurst_t7", 32'(cpu_reset_o), 32'd1);
    check("basic_busy_t7", 32'(busy_o), 32'd1);
    tick();
    check("basic_done_t8", 32'(done_o), 32'd0);
    check("basic_cpurst_t8", 32'(cpu_reset_o), 32'd0);
    check("basic_busy_t8", 32'(busy_o), 32'd0);
    check("basic_writes", 32'(we_count), 32'd2);
    check("basic_dones", 32'(done_count), 32'd1);
    in_valid_i = 1'b0;
    tick();

    // Backpressure: valid 1,0,0,1 then a stray word held during WRITE/DONE.
    words = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    new_session();
    in_valid_i = 1'b1;
    do_start(16'd1);
    tick();
    in_valid_i = 1'b0;
    check("bp_gap1_we", 32'(pm_we_o), 32'd0);
    check("bp_gap1_ready", 32'(in_ready_o), 32'd1);
    tick();
    check("bp_gap2_we", 32'(pm_we_o), 32'd0);
    tick();
    in_valid_i = 1'b1;
    tick();
    check("bp_we", 32'(pm_we_o), 32'd1);
    check("bp_data", pm_wdata_o, 32'hAAAABBBB);
    tick();
    check("bp_done", 32'(done_o), 32'd1);
    check("bp_ready_done", 32'(in_ready_o), 32'd0);
    tick();
    check("bp_consumed", 32'(widx), 32'd2);
    check("bp_writes", 32'(we_count), 32'd1);
    in_valid_i = 1'b0;
    tick();

    // Rejected starts: zero length and one past the memory depth.
    new_session();
    do_start(16'd0);
    check("rej0_err", 32'(err_o), 32'd1);
    check("rej0_busy", 32'(busy_o), 32'd0);
    check("rej0_cpurst", 32'(cpu_reset_o), 32'd0);
    tick();
    check("rej0_err_clr", 32'(err_o), 32'd0);
    do_start(16'd257);
    check("rej257_err", 32'(err_o), 32'd1);
    check("rej257_busy", 32'(busy_o), 32'd0);
    check("rej257_ready", 32'(in_ready_o), 32'd0);
    tick();
    check("rej257_err_clr", 32'(err_o), 32'd0);
    check("rej_err_count", 32'(err_count), 32'd2);
    check("rej_writes", 32'(we_count), 32'd0);
    check("rej_cpurst_kept", 32'(cpu_reset_o), 32'd0);

    // Reset in the middle of a four-instruction load.
    words = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005, 16'h1006, 16'h1007};
    new_session();
    in_valid_i = 1'b1;
    do_start(16'd4);
    cyc = 0;
    while (we_count < 2 && cyc < 50) begin
      tick();
      cyc++;
    end
    check("mid_two_writes", 32'(we_count), 32'd2);
    #2 reset_i = 1'b1;
    #1;
    check("mid_rst_ready", 32'(in_ready_o), 32'd0);
    check("mid_rst_we", 32'(pm_we_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_cpurst", 32'(cpu_reset_o), 32'd1);
    check("mid_rst_done", 32'(done_o), 32'd0);
    check("mid_rst_addr", 32'(pm_addr_o), 32'd0);
    @(posedge clk);
    #1 reset_i = 1'b0;
    words = '{16'h4444, 16'h5555};
    new_session();
    do_start(16'd1);
    tick(); tick(); tick();
    check("reload_done", 32'(done_o), 32'd1);
    check("reload_writes", 32'(we_count), 32'd1);
    check("reload_addr", 32'(last_addr), 32'd0);
    in_valid_i = 1'b0;
    tick(); tick();

    // Full-depth load with start pulses mid-session that must be ignored.
    words = {};
    for (int i = 0; i < 512; i++) words.push_back(16'(i * 7 + 3));
    new_session();
    in_valid_i = 1'b1;
    do_start(16'd256);
    cyc = 0;
    while (done_count == 0 && cyc < 2000) begin
      start_i    = (cyc == 5 || cyc == 300);
      load_len_i = 16'd5;
      tick();
      cyc++;
    end
    start_i = 1'b0;
    check("full_cycles", 32'(cyc), 32'd769);
    check("full_writes", 32'(we_count), 32'd256);
    check("full_last_addr", 32'(last_addr), 32'h00FF);
    check("full_dones", 32'(done_count), 32'd1);
    check("full_no_err", 32'(err_count), 32'd0);
    check("full_cpurst", 32'(cpu_reset_o), 32'd0);
    check("full_busy", 32'(busy_o), 32'd0);
    in_valid_i = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
